mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the arbiter and a single-port memory.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_adr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_done;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
    input  mem_rdata,
    output cpu_done, cpu_rdata, dbg_done, dbg_rdata,
    output mem_adr, mem_wdata, mem_we, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output dbg_req, dbg_we, dbg_adr, dbg_wdata,
    output mem_rdata,
    input  cpu_done, cpu_rdata, dbg_done, dbg_rdata,
    input  mem_adr, mem_wdata, mem_we, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug loader) arbiter for a single-port memory with a fixed
// three-cycle IDLE -> ACCESS -> DONE transaction and round-robin or CPU-priority arbitration.
module mem_arbiter #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int RR = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10} state_e;

  state_e        state_q, state_d;
  logic          last_dbg_q, last_dbg_d;
  logic          own_dbg_q, own_dbg_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          grant_cpu, grant_dbg, grant;
  logic          done_act;

  // On a tie, round-robin favours whoever was not granted last; otherwise the CPU wins.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (bus.cpu_req && bus.dbg_req) begin
      if (RR == 0 || last_dbg_q) grant_cpu = 1'b1;
      else                       grant_dbg = 1'b1;
    end else begin
      grant_cpu = bus.cpu_req;
      grant_dbg = bus.dbg_req;
    end
  end

  assign grant = (state_q == IDLE) && (grant_cpu || grant_dbg);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Done is masked by reset so a reset landing in DONE aborts without a pulse.
  always_comb begin
    done_act      = (state_q == DONE) && !reset;
    bus.mem_we    = (state_q == ACCESS) && we_q;
    bus.mem_adr   = adr_q;
    bus.mem_wdata = wdata_q;
    bus.cpu_done  = done_act && !own_dbg_q;
    bus.dbg_done  = done_act && own_dbg_q;
    bus.cpu_rdata = (bus.cpu_done && !we_q) ? bus.mem_rdata : cpu_rdata_q;
    bus.dbg_rdata = (bus.dbg_done && !we_q) ? bus.mem_rdata : dbg_rdata_q;
    case (state_q)
      ACCESS, DONE: bus.owner = own_dbg_q ? 2'b10 : 2'b01;
      default:      bus.owner = 2'b00;
    endcase
  end

  // Winner's request is captured at grant so later input changes cannot disturb it.
  always_comb begin
    last_dbg_d  = last_dbg_q;
    own_dbg_d   = own_dbg_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = bus.cpu_rdata;
    dbg_rdata_d = bus.dbg_rdata;
    if (grant) begin
      last_dbg_d = grant_dbg;
      own_dbg_d  = grant_dbg;
      we_d       = grant_dbg ? bus.dbg_we    : bus.cpu_we;
      adr_d      = grant_dbg ? bus.dbg_adr   : bus.cpu_adr;
      wdata_d    = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dbg_q  <= 1'b1;
      own_dbg_q   <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      last_dbg_q  <= last_dbg_d;
      own_dbg_q   <= own_dbg_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter, each with a small
// synchronous memory model that returns read data one cycle after the address.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DW(16), .AW(16)) b0 ();
  mem_arbiter_if #(.DW(16), .AW(16)) b1 ();

  mem_arbiter #(.DW(16), .AW(16), .RR(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
  mem_arbiter #(.DW(16), .AW(16), .RR(0)) u1 (.clk(clk), .reset(reset), .bus(b1));

  logic [15:0] m0 [0:255];
  logic [15:0] m1 [0:255];

  always @(posedge clk) begin
    if (reset) begin
      m0[8'h05] <= 16'h5555;
      m0[8'h09] <= 16'h9999;
      m0[8'h10] <= 16'hBEEF;
      m0[8'h40] <= 16'h4444;
    end else if (b0.mem_we) begin
      m0[b0.mem_adr[7:0]] <= b0.mem_wdata;
    end
    b0.mem_rdata <= m0[b0.mem_adr[7:0]];
  end

  always @(posedge clk) begin
    if (reset) begin
      m1[8'h10] <= 16'hBEEF;
      m1[8'h40] <= 16'h4444;
    end else if (b1.mem_we) begin
      m1[b1.mem_adr[7:0]] <= b1.mem_wdata;
    end
    b1.mem_rdata <= m1[b1.mem_adr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_adr = '0; b0.cpu_wdata = '0;
    b0.dbg_req = 0; b0.dbg_we = 0; b0.dbg_adr = '0; b0.dbg_wdata = '0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_adr = '0; b1.cpu_wdata = '0;
    b1.dbg_req = 0; b1.dbg_we = 0; b1.dbg_adr = '0; b1.dbg_wdata = '0;

    // Reset values
    step(); step(); smp();
    chk("rst_owner",     b0.owner, 0);
    chk("rst_mem_we",    b0.mem_we, 0);
    chk("rst_mem_adr",   b0.mem_adr, 0);
    chk("rst_mem_wdata", b0.mem_wdata, 0);
    chk("rst_cpu_done",  b0.cpu_done, 0);
    chk("rst_dbg_done",  b0.dbg_done, 0);
    chk("rst_cpu_rdata", b0.cpu_rdata, 0);
    chk("rst_dbg_rdata", b0.dbg_rdata, 0);
    chk("rst_fp_owner",  b1.owner, 0);
    step(); reset = 1'b0;
    smp(); chk("idle_no_req", b0.owner, 0);

    // CPU alone reads 0x0010
    step(); b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_adr = 16'h0010;
    smp(); chk("rd_grant_owner", b0.owner, 0);
    step(); b0.cpu_req = 0;
    smp();
    chk("rd_acc_adr",   b0.mem_adr, 16'h0010);
    chk("rd_acc_owner", b0.owner, 1);
    chk("rd_acc_we",    b0.mem_we, 0);
    chk("rd_acc_done",  b0.cpu_done, 0);
    step(); smp();
    chk("rd_done",       b0.cpu_done, 1);
    chk("rd_rdata",      b0.cpu_rdata, 16'hBEEF);
    chk("rd_dbg_done",   b0.dbg_done, 0);
    chk("rd_done_owner", b0.owner, 1);
    step(); smp();
    chk("rd_post_done",  b0.cpu_done, 0);
    chk("rd_post_owner", b0.owner, 0);
    chk("rd_hold_rdata", b0.cpu_rdata, 16'hBEEF);
    chk("rd_hold_adr",   b0.mem_adr, 16'h0010);

    // Debug alone writes 0x1234 to 0x0020
    step(); b0.dbg_req = 1; b0.dbg_we = 1; b0.dbg_adr = 16'h0020; b0.dbg_wdata = 16'h1234;
    step(); b0.dbg_req = 0; b0.dbg_we = 0; b0.dbg_wdata = 16'h0000;
    smp();
    chk("wr_acc_we",    b0.mem_we, 1);
    chk("wr_acc_adr",   b0.mem_adr, 16'h0020);
    chk("wr_acc_wdata", b0.mem_wdata, 16'h1234);
    chk("wr_acc_owner", b0.owner, 2);
    step(); smp();
    chk("wr_done_we",     b0.mem_we, 0);
    chk("wr_done",        b0.dbg_done, 1);
    chk("wr_done_owner",  b0.owner, 2);
    chk("wr_cpu_done",    b0.cpu_done, 0);
    chk("wr_cpu_rdata",   b0.cpu_rdata, 16'hBEEF);
    chk("wr_dbg_rdata",   b0.dbg_rdata, 0);
    step(); smp();
    chk("wr_post_owner", b0.owner, 0);
    chk("wr_post_done",  b0.dbg_done, 0);
    chk("wr_post_we",    b0.mem_we, 0);
    chk("wr_mem_cell",   m0[8'h20], 16'h1234);

    // Continuous contention after reset: RR alternates, fixed priority always CPU
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_adr = 16'h0010;
    b0.dbg_req = 1; b0.dbg_we = 0; b0.dbg_adr = 16'h0040;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_adr = 16'h0010;
    b1.dbg_req = 1; b1.dbg_we = 0; b1.dbg_adr = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      bit c;
      c = (i % 2 == 0);
      step(); smp();
      chk("rr_acc_owner", b0.owner, c ? 32'd1 : 32'd2);
      chk("fp_acc_owner", b1.owner, 1);
      step(); smp();
      chk("rr_cpu_done", b0.cpu_done, c);
      chk("rr_dbg_done", b0.dbg_done, !c);
      chk("fp_cpu_done", b1.cpu_done, 1);
      chk("fp_dbg_done", b1.dbg_done, 0);
      if (c) chk("rr_cpu_rdata", b0.cpu_rdata, 16'hBEEF);
      else   chk("rr_dbg_rdata", b0.dbg_rdata, 16'h4444);
      step();
      if (i == 3) begin
        b0.cpu_req = 0; b0.dbg_req = 0;
        b1.cpu_req = 0; b1.dbg_req = 0;
      end
      smp();
      chk("rr_idle_owner", b0.owner, 0);
    end

    // Address changed after grant must not affect the transaction
    step(); b0.cpu_req = 1; b0.cpu_we = 0; b0.cpu_adr = 16'h0005;
    step(); b0.cpu_req = 0; b0.cpu_adr = 16'h0009;
    smp(); chk("lat_acc_adr", b0.mem_adr, 16'h0005);
    step(); smp();
    chk("lat_done",  b0.cpu_done, 1);
    chk("lat_rdata", b0.cpu_rdata, 16'h5555);
    step(); smp(); chk("lat_idle", b0.owner, 0);

    // Reset in the ACCESS cycle of a write aborts it
    step(); b0.cpu_req = 1; b0.cpu_we = 1; b0.cpu_adr = 16'h0030; b0.cpu_wdata = 16'hAAAA;
    step(); b0.cpu_req = 0; b0.cpu_we = 0; reset = 1'b1;
    smp(); chk("ab_acc_we", b0.mem_we, 1);
    step(); reset = 1'b0;
    b0.cpu_req = 1; b0.cpu_adr = 16'h0010;
    b0.dbg_req = 1; b0.dbg_adr = 16'h0040;
    smp();
    chk("ab_we",        b0.mem_we, 0);
    chk("ab_cpu_done",  b0.cpu_done, 0);
    chk("ab_dbg_done",  b0.dbg_done, 0);
    chk("ab_owner",     b0.owner, 0);
    chk("ab_adr",       b0.mem_adr, 0);
    chk("ab_wdata",     b0.mem_wdata, 0);
    chk("ab_cpu_rdata", b0.cpu_rdata, 0);
    chk("ab_dbg_rdata", b0.dbg_rdata, 0);
    step(); b0.cpu_req = 0; b0.dbg_req = 0;
    smp(); chk("ab_tie_owner", b0.owner, 1);
    step(); smp();
    chk("ab_tie_done",  b0.cpu_done, 1);
    chk("ab_tie_dbg",   b0.dbg_done, 0);
    step(); smp();
    chk("ab_end_owner", b0.owner, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
